// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the SDRAM read-port arbiter.
// maxTrans sets the largest burst length; it defaults to 16 when no build define supplies it.
`ifndef maxTrans
`define maxTrans 16
`endif

package mem_arb_pkg;
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} arb_state_t;

  localparam int SDRAM_ADDR_W = 25;
  localparam int SDRAM_DATA_W = 32;
endpackage

// File: rtl/mem_req_arbiter_if.sv
// Client-side and SDRAM-side read-port bundle; master is the arbiter's view, slave the environment's.
interface mem_req_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int TS_W        = $clog2(`maxTrans)
);
  logic [NUM_CLIENTS-1:0][SDRAM_ADDR_W-1:0] cl_addr;
  logic [NUM_CLIENTS-1:0][TS_W-1:0]         cl_transSize;
  logic [NUM_CLIENTS-1:0]                   cl_readReq;
  logic [NUM_CLIENTS-1:0]                   cl_readValid_out;
  logic [SDRAM_DATA_W-1:0]                  cl_readData;
  logic [NUM_CLIENTS-1:0]                   cl_doneRead;
  logic [SDRAM_ADDR_W-1:0]                  addr_cache_to_sdram;
  logic [TS_W-1:0]                          transSize;
  logic                                     readReq;
  logic                                     readValid_out;
  logic [SDRAM_DATA_W-1:0]                  readData;
  logic                                     doneRead;

  modport master (
    input  cl_addr, cl_transSize, cl_readReq, readValid_out, readData, doneRead,
    output cl_readValid_out, cl_readData, cl_doneRead, addr_cache_to_sdram, transSize, readReq
  );
  modport slave (
    output cl_addr, cl_transSize, cl_readReq, readValid_out, readData, doneRead,
    input  cl_readValid_out, cl_readData, cl_doneRead, addr_cache_to_sdram, transSize, readReq
  );
endinterface

// File: rtl/mem_req_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit scanning upward from rr_ptr, with wrap.
module rr_pick #(
  parameter int N     = 4,
  parameter int CLI_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [CLI_W-1:0] rr_ptr,
  output logic             any_req,
  output logic [CLI_W-1:0] pick
);
  logic [CLI_W:0] idx;

  // Scan from the farthest offset down so the nearest requester wins; wrap by compare, not truncation.
  always_comb begin
    any_req = |req;
    pick    = '0;
    idx     = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = {1'b0, rr_ptr} + (CLI_W+1)'(k);
      if (idx >= (CLI_W+1)'(N)) idx = idx - (CLI_W+1)'(N);
      if (req[idx[CLI_W-1:0]]) pick = idx[CLI_W-1:0];
    end
  end
endmodule

// File: rtl/mem_req_arbiter.sv
// Round-robin arbiter sharing one SDRAM read port among NUM_CLIENTS miss handlers.
// Optional MEM_ARB_BEAT_CHECK_EN adds a beat counter and sticky err_beat output.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CLIENTS = 4,
  parameter int TS_W        = $clog2(`maxTrans),
  parameter int CLI_W       = $clog2(NUM_CLIENTS)
) (
  input  logic              clk,
  input  logic              rst,
  mem_req_arbiter_if.master bus,
  output logic              busy,
  output logic [CLI_W-1:0]  grant_id
`ifdef MEM_ARB_BEAT_CHECK_EN
  ,
  output logic              err_beat
`endif
);
  arb_state_t       state, state_nxt;
  logic [CLI_W-1:0] rr_ptr, rr_nxt, grant_nxt, pick;
  logic             any_req;

  rr_pick #(.N(NUM_CLIENTS), .CLI_W(CLI_W)) u_pick (
    .req     (bus.cl_readReq),
    .rr_ptr  (rr_ptr),
    .any_req (any_req),
    .pick    (pick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
    end else begin
      state    <= state_nxt;
      rr_ptr   <= rr_nxt;
      grant_id <= grant_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    grant_nxt = grant_id;
    rr_nxt    = rr_ptr;
    case (state)
      IDLE: if (any_req) begin
        state_nxt = BUSY;
        grant_nxt = pick;
      end
      BUSY: if (bus.doneRead) begin
        state_nxt = IDLE;
        rr_nxt    = (grant_id == CLI_W'(NUM_CLIENTS - 1)) ? '0 : grant_id + 1'b1;
      end
    endcase
  end

  assign busy                    = (state == BUSY);
  assign bus.readReq             = busy & bus.cl_readReq[grant_id];
  assign bus.addr_cache_to_sdram = bus.cl_addr[grant_id];
  assign bus.transSize           = bus.cl_transSize[grant_id];
  assign bus.cl_readData         = bus.readData;

  // Strobes reach only the granted client; anything arriving in IDLE is dropped.
  for (genvar i = 0; i < NUM_CLIENTS; i++) begin : g_cl
    assign bus.cl_readValid_out[i] = busy && (grant_id == CLI_W'(i)) && bus.readValid_out;
    assign bus.cl_doneRead[i]      = busy && (grant_id == CLI_W'(i)) && bus.doneRead;
  end

`ifdef MEM_ARB_BEAT_CHECK_EN
  logic [TS_W:0] beat_cnt, beats_now;

  // beats_now folds in a beat landing in the same cycle as doneRead.
  assign beats_now = beat_cnt + (TS_W+1)'(bus.readValid_out);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_cnt <= '0;
      err_beat <= 1'b0;
    end else begin
      if (state == IDLE)           beat_cnt <= '0;
      else if (bus.readValid_out)  beat_cnt <= beats_now;
      if (busy && bus.doneRead && (beats_now != {1'b0, bus.transSize})) err_beat <= 1'b1;
      if (!busy && (bus.readValid_out || bus.doneRead))                err_beat <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_mem_req_arbiter.sv
// Self-checking bench for mem_req_arbiter: picker table, directed sequences, randomized model check.
module tb_mem_req_arbiter;
  import mem_arb_pkg::*;

  localparam int NC   = 4;
  localparam int CW   = 2;
  localparam int TS_W = $clog2(`maxTrans);
`ifdef MEM_ARB_BEAT_CHECK_EN
  localparam bit STRAY = 1'b0;
`else
  localparam bit STRAY = 1'b1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          busy;
  logic [CW-1:0] grant_id;
`ifdef MEM_ARB_BEAT_CHECK_EN
  logic          err_beat;
`endif
  int n_chk = 0;
  int n_fail = 0;

  mem_req_arbiter_if #(.NUM_CLIENTS(NC), .TS_W(TS_W)) bus ();

  mem_req_arbiter #(.NUM_CLIENTS(NC), .TS_W(TS_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .busy     (busy),
    .grant_id (grant_id)
`ifdef MEM_ARB_BEAT_CHECK_EN
    ,
    .err_beat (err_beat)
`endif
  );

  // Standalone pickers: 4-way for the table, 3-way for non-power-of-2 wrap.
  logic [3:0] pk_req;  logic [1:0] pk_ptr;  logic pk_any;  logic [1:0] pk_pick;
  logic [2:0] p3_req;  logic [1:0] p3_ptr;  logic p3_any;  logic [1:0] p3_pick;
  rr_pick #(.N(4)) u_pk  (.req(pk_req), .rr_ptr(pk_ptr), .any_req(pk_any), .pick(pk_pick));
  rr_pick #(.N(3)) u_pk3 (.req(p3_req), .rr_ptr(p3_ptr), .any_req(p3_any), .pick(p3_pick));

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.cl_readReq = '0; bus.readValid_out = 1'b0; bus.doneRead = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Deliver nb beats then doneRead to granted client c; optionally raise another request in the done cycle.
  task automatic burst(input int c, input int nb, input int late);
    logic [NC-1:0] e;
    logic [31:0]   d;
    e = NC'(1) << c;
    for (int b = 0; b < nb; b++) begin
      @(negedge clk);
      d = $urandom; bus.readValid_out = 1'b1; bus.readData = d; #1;
      chk("beat_strobe", bus.cl_readValid_out, e);
      chk("beat_data", bus.cl_readData, d);
      chk("beat_no_done", bus.cl_doneRead, 0);
    end
    @(negedge clk);
    bus.readValid_out = 1'b0; bus.doneRead = 1'b1;
    if (late >= 0) bus.cl_readReq = bus.cl_readReq | (NC'(1) << late);
    #1;
    chk("done_strobe", bus.cl_doneRead, e);
    chk("done_busy", busy, 1);
    @(negedge clk);
    bus.doneRead = 1'b0; bus.cl_readReq = bus.cl_readReq & ~e; #1;
    chk("gap_busy", busy, 0);
    chk("gap_readReq", bus.readReq, 0);
  endtask

  task automatic set_cl(input logic [CW-1:0] c, input logic [24:0] a, input logic [TS_W-1:0] t);
    bus.cl_addr[c] = a; bus.cl_transSize[c] = t;
  endtask

  typedef struct {
    logic [3:0] req;
    logic [1:0] ptr;
    logic       any;
    logic [1:0] pick;
  } pk_vec_t;
  pk_vec_t tbl[10];

  // Random-phase model state
  logic [NC-1:0]   pend, e_rv, e_dn;
  logic [24:0]     ca[NC];
  logic [TS_W-1:0] cts[NC];
  logic [CW-1:0]   mg;
  int              last, left;
  logic            mbusy, rv, dn;

  initial begin
    rst = 1'b1;
    bus.cl_readReq = '0; bus.readValid_out = 1'b0; bus.doneRead = 1'b0; bus.readData = '0;
    for (int i = 0; i < NC; i++) set_cl(CW'(i), 25'h1000 + 25'(i), TS_W'(1));
    pk_req = '0; pk_ptr = '0; p3_req = '0; p3_ptr = '0;

    // Picker table
    tbl[0] = '{4'b0000, 2'd0, 1'b0, 2'd0};
    tbl[1] = '{4'b0001, 2'd0, 1'b1, 2'd0};
    tbl[2] = '{4'b1010, 2'd3, 1'b1, 2'd3};
    tbl[3] = '{4'b0010, 2'd3, 1'b1, 2'd1};
    tbl[4] = '{4'b1111, 2'd2, 1'b1, 2'd2};
    tbl[5] = '{4'b0101, 2'd1, 1'b1, 2'd2};
    tbl[6] = '{4'b1000, 2'd0, 1'b1, 2'd3};
    tbl[7] = '{4'b0001, 2'd3, 1'b1, 2'd0};
    tbl[8] = '{4'b0110, 2'd3, 1'b1, 2'd1};
    tbl[9] = '{4'b1111, 2'd0, 1'b1, 2'd0};
    for (int i = 0; i < 10; i++) begin
      pk_req = tbl[i].req; pk_ptr = tbl[i].ptr; #1;
      chk("pick_any", pk_any, tbl[i].any);
      if (tbl[i].any) chk("pick_idx", pk_pick, tbl[i].pick);
    end
    p3_req = 3'b001; p3_ptr = 2'd2; #1; chk("pick3_wrap", p3_pick, 0);
    p3_req = 3'b011; p3_ptr = 2'd2; #1; chk("pick3_wrap2", p3_pick, 0);
    p3_req = 3'b110; p3_ptr = 2'd2; #1; chk("pick3_top", p3_pick, 2);

    // Reset values
    @(negedge clk); #1;
    chk("rst_busy", busy, 0);
    chk("rst_readReq", bus.readReq, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_rv", bus.cl_readValid_out, 0);
    chk("rst_done", bus.cl_doneRead, 0);
    chk("rst_addr", bus.addr_cache_to_sdram, 25'h1000);
`ifdef MEM_ARB_BEAT_CHECK_EN
    chk("rst_err", err_beat, 0);
`endif
    @(negedge clk); rst = 1'b0;

    // Single request, then wrap from rr_ptr=3 with clients 1 and 3
    @(negedge clk);
    set_cl(2'd2, 25'h00100, TS_W'(8)); bus.cl_readReq = 4'b0100; #1;
    chk("single_t0_readReq", bus.readReq, 0);
    @(negedge clk); #1;
    chk("single_readReq", bus.readReq, 1);
    chk("single_grant", grant_id, 2);
    chk("single_addr", bus.addr_cache_to_sdram, 25'h00100);
    chk("single_ts", bus.transSize, 8);
    burst(2, 8, -1);
    set_cl(2'd1, 25'h0AAAA, TS_W'(2)); set_cl(2'd3, 25'h13333, TS_W'(2));
    bus.cl_readReq = 4'b1010;
    @(negedge clk); #1;
    chk("wrap_first", grant_id, 3);
    chk("wrap_addr", bus.addr_cache_to_sdram, 25'h13333);
    burst(3, 2, -1);
    @(negedge clk); #1;
    chk("wrap_second", grant_id, 1);
    chk("wrap_busy", busy, 1);
    burst(1, 2, -1);

    // All four requesting: 0,1,2,3 with one-cycle gaps
    do_reset();
    for (int i = 0; i < NC; i++) set_cl(CW'(i), 25'h2000 + 25'(i * 16), TS_W'(8));
    bus.cl_readReq = 4'b1111;
    for (int g = 0; g < NC; g++) begin
      @(negedge clk); #1;
      chk("all_grant", grant_id, g);
      chk("all_readReq", bus.readReq, 1);
      chk("all_addr", bus.addr_cache_to_sdram, 25'h2000 + 25'(g * 16));
      burst(g, 8, -1);
    end

    // Request in the doneRead cycle waits for IDLE
    do_reset();
    bus.cl_readReq = 4'b0010;
    @(negedge clk); #1;
    chk("late_first", grant_id, 1);
    burst(1, 3, 0);
    @(negedge clk); #1;
    chk("late_busy", busy, 1);
    chk("late_grant", grant_id, 0);
    burst(0, 1, -1);

    // Async reset mid-burst
    do_reset();
    set_cl(2'd0, 25'h00777, TS_W'(5)); set_cl(2'd1, 25'h1ABCD, TS_W'(5));
    bus.cl_readReq = 4'b0010;
    @(negedge clk); #1;
    chk("mid_grant", grant_id, 1);
    for (int b = 0; b < 3; b++) begin @(negedge clk); bus.readValid_out = 1'b1; end
    @(negedge clk); bus.readValid_out = 1'b1; #2; rst = 1'b1; #1;
    chk("mid_busy", busy, 0);
    chk("mid_readReq", bus.readReq, 0);
    chk("mid_grant_rst", grant_id, 0);
    chk("mid_rv", bus.cl_readValid_out, 0);
    chk("mid_addr", bus.addr_cache_to_sdram, 25'h00777);
    @(negedge clk); bus.readValid_out = 1'b0; rst = 1'b0;
    @(negedge clk); #1;
    chk("mid_regrant", grant_id, 1);
    chk("mid_regrant_busy", busy, 1);
    burst(1, 5, -1);

    // Granted client drops early: readReq follows, grant held until doneRead
    do_reset();
    bus.cl_readReq = 4'b1000;
    @(negedge clk); #1; chk("drop_grant", grant_id, 3);
    @(negedge clk); bus.cl_readReq = 4'b0000; #1;
    chk("drop_readReq", bus.readReq, 0);
    chk("drop_busy", busy, 1);
    @(negedge clk); bus.doneRead = 1'b1; #1;
    chk("drop_done", bus.cl_doneRead, 4'b1000);
    @(negedge clk); bus.doneRead = 1'b0; #1;
    chk("drop_idle", busy, 0);

    // Stray strobes in IDLE
    @(negedge clk); bus.readValid_out = 1'b1; bus.doneRead = 1'b1; #1;
    chk("stray_rv", bus.cl_readValid_out, 0);
    chk("stray_dn", bus.cl_doneRead, 0);
    @(negedge clk); bus.readValid_out = 1'b0; bus.doneRead = 1'b0; #1;
    chk("stray_busy", busy, 0);
`ifdef MEM_ARB_BEAT_CHECK_EN
    chk("stray_err", err_beat, 1);
    do_reset(); #1;
    chk("err_cleared", err_beat, 0);
`endif

    // Randomized traffic against a fairness model
    do_reset();
    pend = '0; mbusy = 1'b0; mg = '0; left = 0; last = NC - 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NC; i++)
        if (!pend[CW'(i)] && $urandom_range(7) == 0) begin
          pend[CW'(i)] = 1'b1;
          ca[CW'(i)] = 25'($urandom); cts[CW'(i)] = TS_W'($urandom_range(15, 1));
          set_cl(CW'(i), ca[CW'(i)], cts[CW'(i)]);
        end
      bus.cl_readReq = pend;
      rv = 1'b0; dn = 1'b0;
      if (mbusy) begin
        if (left > 0) rv = ($urandom_range(3) != 0);
        else          dn = ($urandom_range(2) == 0);
      end else if (STRAY) begin
        rv = ($urandom_range(7) == 0); dn = ($urandom_range(7) == 0);
      end
      bus.readValid_out = rv; bus.doneRead = dn; bus.readData = $urandom;
      #1;
      e_rv = '0; e_dn = '0;
      if (mbusy) begin e_rv[mg] = rv; e_dn[mg] = dn; end
      chk("rnd_busy", busy, mbusy);
      chk("rnd_readReq", bus.readReq, mbusy);
      if (mbusy) begin
        chk("rnd_grant", grant_id, mg);
        chk("rnd_addr", bus.addr_cache_to_sdram, ca[mg]);
        chk("rnd_ts", bus.transSize, cts[mg]);
      end
      chk("rnd_rv", bus.cl_readValid_out, e_rv);
      chk("rnd_dn", bus.cl_doneRead, e_dn);
      chk("rnd_data", bus.cl_readData, bus.readData);
      // Served client goes to the back of the line
      if (mbusy) begin
        if (rv) left--;
        if (dn) begin pend[mg] = 1'b0; last = int'(mg); mbusy = 1'b0; end
      end else if (pend != '0) begin
        for (int k = NC; k >= 1; k--)
          if (pend[CW'((last + k) % NC)]) mg = CW'((last + k) % NC);
        mbusy = 1'b1; left = int'(cts[mg]);
      end
    end
`ifdef MEM_ARB_BEAT_CHECK_EN
    chk("rnd_no_err", err_beat, 0);
`endif

    // Short burst: 7 beats against transSize 8
    do_reset();
    set_cl(2'd0, 25'h00400, TS_W'(8)); bus.cl_readReq = 4'b0001;
    @(negedge clk); #1; chk("short_grant", grant_id, 0);
    burst(0, 7, -1);
`ifdef MEM_ARB_BEAT_CHECK_EN
    chk("short_err", err_beat, 1);
    repeat (3) @(negedge clk);
    #1; chk("short_err_sticky", err_beat, 1);
`else
    chk("short_no_hang", bus.cl_readValid_out, 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Shares the single SDRAM read port (25-bit word address, burst length, 32-bit read data) among NUM_CLIENTS cache miss handlers.
- Each client holds readReq, address and transSize stable until it receives doneRead.
- The arbiter grants one client at a time in round-robin order and forwards that client's request to the SDRAM controller.
- It steers the readValid/doneRead strobes back to the granted client only.

Parameters:
- NUM_CLIENTS, 4, number of miss-handler clients (2..8).
- TS_W, $clog2(`maxTrans), width of the transSize field.
- CLI_W, $clog2(NUM_CLIENTS), width of client index.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- cl_addr  in  [NUM_CLIENTS][24:0]  per-client SDRAM word address.
- cl_transSize  in  [NUM_CLIENTS][TS_W-1:0]  per-client burst length in 32-bit beats.
- cl_readReq  in  [NUM_CLIENTS]  per-client read request, level, held until that client's doneRead.
- cl_readValid_out  out  [NUM_CLIENTS]  per-client data-beat strobe.
- cl_readData  out  32  read data, broadcast to all clients.
- cl_doneRead  out  [NUM_CLIENTS]  per-client burst-complete strobe.
- addr_cache_to_sdram  out  25  address to the SDRAM controller.
- transSize  out  TS_W  burst length to the SDRAM controller.
- readReq  out  1  request to the SDRAM controller.
- readValid_out  in  1  SDRAM data-beat strobe.
- readData  in  32  SDRAM read data.
- doneRead  in  1  SDRAM burst complete.
- busy  out  1  high while a grant is held.
- grant_id  out  CLI_W  index of the granted client; valid when busy.

Behaviour:
- Reset values (async, immediate): state IDLE, rr_ptr=0, grant_id=0, busy=0, readReq=0, all cl_readValid_out=0, all cl_doneRead=0. addr_cache_to_sdram and transSize show client 0's fields (don't-care while readReq=0).
- States:
  - IDLE: readReq=0. If any cl_readReq is set, the picker selects the first requesting index scanning rr_ptr, rr_ptr+1, ... with wrap mod NUM_CLIENTS. grant_id is registered and the next state is BUSY.
  - BUSY: readReq = cl_readReq[grant_id]. addr_cache_to_sdram and transSize are combinational muxes of the granted client's fields.
    - cl_readValid_out[grant_id] = readValid_out; cl_doneRead[grant_id] = doneRead; all other indices are 0.
    - On doneRead: next state IDLE, rr_ptr <= (grant_id+1) mod NUM_CLIENTS. The wrap uses an explicit compare, not power-of-2 truncation, so non-power-of-2 NUM_CLIENTS works.
- Latency: client request at cycle t gives SDRAM readReq at t+1. After doneRead at t, the earliest next grant is registered at t+1 and SDRAM readReq goes high at t+2. The minimum idle bubble is one cycle.
- Fairness: a client that has just been served has the lowest priority next. With all clients requesting continuously, the grant order is 0,1,2,3,0,...
- cl_readData = readData at all times; clients qualify it with their own readValid strobe.
- readValid_out or doneRead arriving in IDLE: ignored, not forwarded, no state change.
- Granted client drops cl_readReq before doneRead (protocol violation): readReq follows it low. The grant is kept until doneRead.
- A request arriving in the same cycle as doneRead is not considered until IDLE.
- busy = (state==BUSY).
- Reset mid-burst: returns to IDLE. The SDRAM controller shares rst, so there is no orphan burst.

Optional Feature:
- Macro: MEM_ARB_BEAT_CHECK_EN.
- When defined:
  - Adds beat_cnt[TS_W:0], cleared on entry to BUSY and incremented on each readValid_out in BUSY.
  - Adds output err_beat, a sticky flag cleared only by rst.
  - err_beat is set when doneRead occurs with beat_cnt (including a same-cycle beat) != transSize of the granted client.
  - err_beat is also set when readValid_out or doneRead occurs in IDLE.
- When undefined: no counter and no err_beat port; behaviour is otherwise identical.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {IDLE, BUSY}.
  - SDRAM_ADDR_W=25, SDRAM_DATA_W=32.
- Sub-module rr_pick: purely combinational round-robin picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: any_req, pick index.
  - Instantiated once; unit-tested separately.

Test Plan:
- Single request: client 2 requests addr 0x00100 with transSize 8; SDRAM returns 8 beats, then doneRead. Expect readReq high from t+1, addr=0x00100, cl_readValid_out[2] pulses 8 times, cl_doneRead[2] once, all other strobes 0, rr_ptr=3 afterwards.
- All four request at once, each burst 8 beats. Expect grants 0,1,2,3 in order with a one-cycle IDLE gap between bursts, and each client's doneRead arriving only on its own line.
- rr_ptr=3 with clients 1 and 3 requesting. Expect grant 3 first, then 1 (wrap-around).
- Client 0 asserts in the same cycle as doneRead for client 1. Expect no grant in that cycle; grant 0 is registered the next cycle.
- Async rst mid-burst of client 1 after 3 beats. Expect all outputs at reset values immediately, then a clean re-grant after release.
- With MEM_ARB_BEAT_CHECK_EN: doneRead after 7 beats with transSize 8 sets err_beat=1 and keeps it set. Without the macro, the same stimulus completes normally.
